// File: rtl/div_ratio_detect_if.sv
// Slow-signal input and measurement outputs of div_ratio_detect.
// master drives slow_in; slave is the detector.
interface div_ratio_detect_if #(
  parameter int WIDTH = 8
) ();
  logic             slow_in;
  logic [WIDTH-1:0] half_period;
  logic             meas_valid;
  logic             locked;
  logic             mismatch;
  logic             timeout;

  modport master (
    output slow_in,
    input  half_period,
    input  meas_valid,
    input  locked,
    input  mismatch,
    input  timeout
  );

  modport slave (
    input  slow_in,
    output half_period,
    output meas_valid,
    output locked,
    output mismatch,
    output timeout
  );
endinterface

// File: rtl/div_ratio_detect.sv
// Half-period meter for a divided clock seen in the fast domain.
// Reports each edge-to-edge count, ratio lock, drift and stall.
module div_ratio_detect #(
  parameter int WIDTH       = 8,
  parameter int EXPECT_HALF = 8,
  parameter int TOL         = 0,
  parameter int LOCK_COUNT  = 4
) (
  input logic              clk,
  input logic              reset,
  div_ratio_detect_if.slave bus
);

  localparam logic [1:0] S_SEEK  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_MEAS  = 2'd2;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH:0]   EXP_W   = (WIDTH+1)'(EXPECT_HALF);
  localparam logic [WIDTH:0]   TOL_W   = (WIDTH+1)'(TOL);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [3:0]       r_match_cnt;
  logic [WIDTH-1:0] r_half;
  logic             r_meas_valid;
  logic             r_locked;
  logic             r_mismatch;
  logic             r_timeout;

  logic             w_edge;
  logic [WIDTH:0]   w_cnt_x;
  logic [WIDTH:0]   w_diff;
  logic             w_match;
  logic [3:0]       w_match_nxt;

  assign w_edge  = r_sync2 ^ r_prev;
  assign w_cnt_x = {1'b0, r_cnt};
  assign w_diff  = (w_cnt_x >= EXP_W) ?
                   (w_cnt_x - EXP_W) :
                   (EXP_W - w_cnt_x);
  assign w_match = (w_diff <= TOL_W);
  assign w_match_nxt = (r_match_cnt < LOCK_N) ?
                       (r_match_cnt + 4'd1) :
                       r_match_cnt;

  // Two-flop synchronizer plus history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= bus.slow_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Interval counter, seek/prime/measure sequencing, lock tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_SEEK;
      r_cnt        <= '0;
      r_match_cnt  <= '0;
      r_half       <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_mismatch   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      r_mismatch   <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        S_SEEK: begin
          r_cnt <= '0;
          if (w_edge) begin
            r_state <= S_PRIME;
            r_cnt   <= CNT_ONE;
          end
        end
        S_PRIME: begin
          if (w_edge) begin
            r_state <= S_MEAS;
            r_cnt   <= CNT_ONE;
          end else if (r_cnt == CNT_MAX) begin
            r_state     <= S_SEEK;
            r_cnt       <= '0;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_MEAS: begin
          if (w_edge) begin
            r_half       <= r_cnt;
            r_meas_valid <= 1'b1;
            r_cnt        <= CNT_ONE;
            if (w_match) begin
              r_match_cnt <= w_match_nxt;
              if (w_match_nxt == LOCK_N)
                r_locked <= 1'b1;
            end else begin
              r_match_cnt <= '0;
              r_locked    <= 1'b0;
              r_mismatch  <= 1'b1;
            end
          end else if (r_cnt == CNT_MAX) begin
            r_state     <= S_SEEK;
            r_cnt       <= '0;
            r_match_cnt <= '0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= S_SEEK;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.half_period = r_half;
  assign bus.meas_valid  = r_meas_valid;
  assign bus.locked      = r_locked;
  assign bus.mismatch    = r_mismatch;
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_div_ratio_detect.sv
// Bench for div_ratio_detect: two configurations share one slow_in.
// An interval-based model predicts every output each cycle.
module tb_div_ratio_detect;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic slow  = 1'b0;

  always #5 clk = ~clk;

  localparam int PW[2] = '{8, 4};
  localparam int PE[2] = '{8, 8};
  localparam int PT[2] = '{0, 1};
  localparam int PL[2] = '{4, 3};

  div_ratio_detect_if #(.WIDTH(8)) bus0 ();
  div_ratio_detect_if #(.WIDTH(4)) bus1 ();

  assign bus0.slow_in = slow;
  assign bus1.slow_in = slow;

  div_ratio_detect #(
    .WIDTH(8), .EXPECT_HALF(8), .TOL(0), .LOCK_COUNT(4)
  ) u0 (
    .clk(clk), .reset(rst), .bus(bus0)
  );

  div_ratio_detect #(
    .WIDTH(4), .EXPECT_HALF(8), .TOL(1), .LOCK_COUNT(3)
  ) u1 (
    .clk(clk), .reset(rst), .bus(bus1)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // model state: sample history, then per instance
  bit q[3];
  int phase[2];
  int last[2];
  int streak[2];
  int hp_m[2];
  bit lk_m[2];
  bit mv_m[2];
  bit mm_m[2];
  bit to_m[2];

  // monitors
  int mvc[2];
  int mmc[2];
  int lastmv[2];
  bit mvseen[2];
  int lock_mv0 = -1;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               n, a, e, cyc);
    end
  endtask

  // Model: an edge is seen when the input sampled two clocks ago
  // differs from the one sampled three clocks ago; intervals are
  // cycle-stamp differences between such edges.
  always @(posedge clk) begin : model
    bit e;
    int m;
    int d;
    cyc++;
    e = (q[1] != q[2]);
    for (int i = 0; i < 2; i++) begin
      mv_m[i] = 1'b0;
      mm_m[i] = 1'b0;
      to_m[i] = 1'b0;
      if (rst) begin
        phase[i]  = 0;
        last[i]   = 0;
        streak[i] = 0;
        hp_m[i]   = 0;
        lk_m[i]   = 1'b0;
      end else if (e) begin
        if (phase[i] == 2) begin
          m = cyc - last[i];
          d = (m > PE[i]) ? m - PE[i] : PE[i] - m;
          hp_m[i] = m;
          mv_m[i] = 1'b1;
          if (d <= PT[i]) begin
            if (streak[i] < PL[i]) streak[i]++;
            if (streak[i] == PL[i]) lk_m[i] = 1'b1;
          end else begin
            streak[i] = 0;
            lk_m[i]   = 1'b0;
            mm_m[i]   = 1'b1;
          end
        end else begin
          phase[i]++;
        end
        last[i] = cyc;
      end else if (phase[i] > 0 &&
                   cyc - last[i] == (1 << PW[i]) - 1) begin
        to_m[i]   = 1'b1;
        phase[i]  = 0;
        streak[i] = 0;
        lk_m[i]   = 1'b0;
      end
    end
    if (rst) begin
      q = '{1'b0, 1'b0, 1'b0};
    end else begin
      q[2] = q[1];
      q[1] = q[0];
      q[0] = slow;
    end
  end

  // Compare every output of both instances each cycle.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("hp0",  int'(bus0.half_period), hp_m[0]);
      chk("mv0",  int'(bus0.meas_valid),  int'(mv_m[0]));
      chk("lk0",  int'(bus0.locked),      int'(lk_m[0]));
      chk("mm0",  int'(bus0.mismatch),    int'(mm_m[0]));
      chk("to0",  int'(bus0.timeout),     int'(to_m[0]));
      chk("hp1",  int'(bus1.half_period), hp_m[1]);
      chk("mv1",  int'(bus1.meas_valid),  int'(mv_m[1]));
      chk("lk1",  int'(bus1.locked),      int'(lk_m[1]));
      chk("mm1",  int'(bus1.mismatch),    int'(mm_m[1]));
      chk("to1",  int'(bus1.timeout),     int'(to_m[1]));
      if (bus0.meas_valid) begin
        mvc[0]++;
        mvseen[0] = 1'b1;
        lastmv[0] = cyc;
        if (bus0.locked && lock_mv0 < 0) lock_mv0 = mvc[0];
      end
      if (bus1.meas_valid) begin
        mvc[1]++;
        mvseen[1] = 1'b1;
        lastmv[1] = cyc;
      end
      if (bus0.mismatch) mmc[0]++;
      if (bus1.mismatch) mmc[1]++;
      if (bus0.timeout) begin
        if (mvseen[0]) chk("to_lat0", cyc - lastmv[0], 255);
        mvseen[0] = 1'b0;
      end
      if (bus1.timeout) begin
        if (mvseen[1]) chk("to_lat1", cyc - lastmv[1], 15);
        mvseen[1] = 1'b0;
      end
      if (rst) begin
        mvseen[0] = 1'b0;
        mvseen[1] = 1'b0;
      end
    end
  end

  task automatic toggles(input int n, input int lo, input int hi);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(hi, lo)) @(negedge clk);
      slow = ~slow;
    end
  endtask

  initial begin : stim
    int base;
    rst  = 1'b1;
    slow = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // steady toggling at the expected ratio
    toggles(12, 8, 8);
    repeat (4) @(negedge clk);
    chk("lit_mv_count", mvc[0], 10);
    chk("lit_mm_count", mmc[0], 0);
    chk("lit_lock_at",  lock_mv0, 4);
    chk("lit_hp8",      int'(bus0.half_period), 8);
    chk("lit_lock",     int'(bus0.locked), 1);
    chk("lit_model_hp", hp_m[0], 8);

    // drift to 9: first measurement drops lock
    base = mmc[0];
    toggles(6, 9, 9);
    repeat (4) @(negedge clk);
    chk("lit_mm9", mmc[0] - base, 6);
    chk("lit_hp9", int'(bus0.half_period), 9);

    // alternating 7/9: inside tolerance only for instance 1
    for (int k = 0; k < 8; k++) begin
      repeat ((k % 2 == 0) ? 7 : 9) @(negedge clk);
      slow = ~slow;
    end
    repeat (4) @(negedge clk);
    chk("lit_tol_lock", int'(bus1.locked), 1);

    // lock, then stall the divider
    toggles(6, 8, 8);
    repeat (300) @(negedge clk);
    chk("lit_to_unlock", int'(bus0.locked), 0);

    // reset in the middle of a measurement while locked
    toggles(8, 8, 8);
    repeat (5) @(negedge clk);
    slow = 1'b1;
    rst  = 1'b1;
    @(negedge clk);
    chk("lit_rst_hp", int'(bus0.half_period), 0);
    chk("lit_rst_lk", int'(bus0.locked), 0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    base = mvc[0];
    repeat (30) @(negedge clk);
    chk("lit_no_bogus_mv", mvc[0] - base, 0);
    toggles(5, 8, 8);

    // edges far apart: narrow counter times out in PRIME
    toggles(4, 20, 20);

    // randomized intervals, stalls and resets
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0)
        toggles(1, 10, 300);
      else
        toggles(1, 5, 11);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
